fft8_seq: RTL and testbench
===========================

Name: fft8_seq

Overview:
- Sequencer for the combinational 8-point FFT core.
- Collects 8 real 32-bit samples from a valid/ready input stream and holds them stable on the core inputs A0..A7.
- Waits a programmable settle latency, captures the 16 core outputs (Xr0..7, Xi0..7), then streams 8 complex bins out in natural order (bin 0 first) over a valid/ready output stream.
- Sits between the sample source and downstream consumer; the FFT core is instantiated outside this block and wired to its core-side ports.

Parameters:
- W, 32, sample/result word width; must match core.
- CORE_LAT, 2, cycles to wait after the 8th sample is loaded before capturing core outputs; legal 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous abort; drops the current frame.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  W  real input sample.
- core_a  out  8*W  held samples to core; A0 = bits [W-1:0] … A7 = top slice.
- core_xr  in  8*W  core real outputs Xr0..Xr7, same packing.
- core_xi  in  8*W  core imag outputs Xi0..Xi7, same packing.
- m_valid  out  1  output bin valid.
- m_ready  in  1  consumer accepts bin.
- m_re  out  W  bin real part.
- m_im  out  W  bin imag part.
- m_idx  out  3  bin index 0..7.
- m_last  out  1  high with bin 7.
- busy  out  1  high in WAIT, CAPT, UNLOAD.
- frame_done  out  1  one-cycle pulse when bin 7 is accepted.

Behaviour:
- Reset (rst_n=0, async) clears everything:
  - state=IDLE; in_cnt=0, out_idx=0, wait_cnt=0.
  - Sample and result registers = 0.
  - s_ready=0, m_valid=0, m_re=m_im=0, m_idx=0, m_last=0, busy=0, frame_done=0.
- States and transitions:
  - IDLE -> LOAD unconditionally on the first clock after reset release. s_ready first goes high 1 cycle after release.
  - LOAD:
    - s_ready=1.
    - Each s_valid&&s_ready beat writes s_data into A[in_cnt], then in_cnt++.
    - The beat that fills A7 moves to WAIT with wait_cnt=CORE_LAT, and in_cnt wraps to 0.
  - WAIT:
    - s_ready=0; core_a is held constant.
    - wait_cnt decrements each cycle; at 0, go to CAPT. With CORE_LAT=0, WAIT lasts exactly 1 cycle.
  - CAPT (1 cycle):
    - Register core_xr/core_xi into the 16 result registers; out_idx=0; go to UNLOAD.
  - UNLOAD:
    - m_valid=1; m_re/m_im = result[out_idx]; m_idx=out_idx; m_last=(out_idx==7).
    - Outputs are registered and stay stable while m_valid&&!m_ready (no change under backpressure).
    - Each m_valid&&m_ready increments out_idx.
    - Acceptance of bin 7 pulses frame_done, drops m_valid next cycle, and goes to LOAD.
- Latency: 8th input beat to first m_valid = CORE_LAT+2 cycles.
- Arithmetic: no arithmetic in this block; results pass through unmodified (wrap/truncation is the core's responsibility).
- core_a changes only on accepted input beats.
- abort:
  - Any state except IDLE -> LOAD next cycle; in_cnt=out_idx=0; m_valid=0; frame_done not pulsed.
  - Sample registers keep stale data (overwritten by next frame).
  - abort with s_valid in the same LOAD cycle: the beat is dropped (abort wins).
- Reset mid-operation: immediate async return to the reset values above; any partial frame is discarded.

Optional Feature:
- Macro FFT8_SEQ_OVERLAP_EN.
- Defined:
  - s_ready is also 1 during UNLOAD while in_cnt<8, so the next frame loads while the current one drains. This is safe because results are already captured.
  - On bin 7 acceptance: if 8 samples are already held, go straight to WAIT; else go to LOAD continuing from in_cnt.
  - If the 8th sample and bin-7 acceptance occur in the same cycle, go to WAIT.
- Undefined:
  - s_ready=0 outside LOAD; in_cnt is always 0 on LOAD entry.

Test Plan:
- Impulse: CORE_LAT=2, feed 1,0,0,0,0,0,0,0 with core model, m_ready=1 -> bins 0..7 all m_re=1, m_im=0; m_last only at idx 7; first m_valid 4 cycles after the 8th beat; one frame_done pulse.
- DC: feed eight 1s -> bin0 m_re=8, all other bins m_re=m_im=0; core_a constant through WAIT/CAPT/UNLOAD.
- Backpressure: m_ready toggling 1,0,0,1… and s_valid gaps -> no bin duplicated or skipped; m_re/m_im/m_idx stable while stalled; s_ready=0 in UNLOAD (macro off).
- Abort: assert abort after 5 loaded samples, then feed a fresh impulse frame -> output is the impulse result only; no frame_done for the aborted frame.
- Async reset: drop rst_n mid-UNLOAD at idx 3 -> m_valid=0 immediately; after release, s_ready=0 one cycle then 1; the next frame is correct.
- FFT8_SEQ_OVERLAP_EN: continuous s_valid, m_ready=1 -> the next 8 samples are accepted during UNLOAD; back-to-back frames with no LOAD gap; frame_done every 8+CORE_LAT+2 cycles.

Source files
------------

// File: rtl/fft8_seq.sv
// Sequencer for a combinational 8-point FFT core: loads 8 samples, waits CORE_LAT, captures, streams 8 bins.
// Optional macro FFT8_SEQ_OVERLAP_EN lets the next frame load while the current one drains.
module fft8_seq #(
  parameter int W        = 32,
  parameter int CORE_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           abort,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  output logic [8*W-1:0] core_a,
  input  logic [8*W-1:0] core_xr,
  input  logic [8*W-1:0] core_xi,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_re,
  output logic [W-1:0]   m_im,
  output logic [2:0]     m_idx,
  output logic           m_last,
  output logic           busy,
  output logic           frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_UNLOAD
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   in_cnt_q, in_cnt_d;
  logic [2:0]   out_idx_q, out_idx_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;
  logic [W-1:0] a_q  [8];
  logic [W-1:0] a_d  [8];
  logic [W-1:0] xr_q [8];
  logic [W-1:0] xr_d [8];
  logic [W-1:0] xi_q [8];
  logic [W-1:0] xi_d [8];
  logic         frame_done_q, frame_done_d;
  logic         in_fire, out_fire;

`ifdef FFT8_SEQ_OVERLAP_EN
  assign s_ready = (state_q == S_LOAD) || ((state_q == S_UNLOAD) && (in_cnt_q < 4'd8));
`else
  assign s_ready = (state_q == S_LOAD);
`endif

  // abort wins over a simultaneous input beat
  assign in_fire  = s_valid && s_ready && !abort;
  assign out_fire = m_valid && m_ready;

  assign m_valid    = (state_q == S_UNLOAD);
  assign m_re       = xr_q[out_idx_q];
  assign m_im       = xi_q[out_idx_q];
  assign m_idx      = out_idx_q;
  assign m_last     = m_valid && (out_idx_q == 3'd7);
  assign busy       = (state_q == S_WAIT) || (state_q == S_CAPT) || (state_q == S_UNLOAD);
  assign frame_done = frame_done_q;

  for (genvar g = 0; g < 8; g++) begin : g_core_a
    assign core_a[g*W +: W] = a_q[g];
  end

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_idx_d    = out_idx_q;
    wait_cnt_d   = wait_cnt_q;
    a_d          = a_q;
    xr_d         = xr_q;
    xi_d         = xi_q;
    frame_done_d = 1'b0;

    if (in_fire) begin
      a_d[in_cnt_q[2:0]] = s_data;
      in_cnt_d           = in_cnt_q + 4'd1;
    end

    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        if (in_fire && (in_cnt_q == 4'd7)) begin
          state_d    = S_WAIT;
          wait_cnt_d = 4'(CORE_LAT);
          in_cnt_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = S_CAPT;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      S_CAPT: begin
        for (int i = 0; i < 8; i++) begin
          xr_d[i] = core_xr[i*W +: W];
          xi_d[i] = core_xi[i*W +: W];
        end
        out_idx_d = 3'd0;
        state_d   = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (out_fire) begin
          out_idx_d = out_idx_q + 3'd1;
          if (out_idx_q == 3'd7) begin
            frame_done_d = 1'b1;
`ifdef FFT8_SEQ_OVERLAP_EN
            // a full frame gathered while draining goes straight to the settle wait
            if (in_cnt_d == 4'd8) begin
              state_d    = S_WAIT;
              wait_cnt_d = 4'(CORE_LAT);
              in_cnt_d   = 4'd0;
            end else begin
              state_d = S_LOAD;
            end
`else
            state_d = S_LOAD;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_LOAD;
      in_cnt_d     = 4'd0;
      out_idx_d    = 3'd0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= 4'd0;
      out_idx_q    <= 3'd0;
      wait_cnt_q   <= 4'd0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        a_q[i]  <= '0;
        xr_q[i] <= '0;
        xi_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_idx_q    <= out_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      frame_done_q <= frame_done_d;
      a_q          <= a_d;
      xr_q         <= xr_d;
      xi_q         <= xi_d;
    end
  end

endmodule

// File: tb/tb_fft8_seq.sv
// Self-checking bench for fft8_seq: table of frames plus abort/reset sequences.
// The FFT core is modelled here as a plain DFT that only gives valid results once core_a has settled.
module tb_fft8_seq;
  localparam int  W  = 32;
  localparam int  CL = 2;
  localparam real PI = 3.14159265358979;

  typedef struct packed {
    logic [7:0][31:0] smp;
    logic [7:0][31:0] er;
    logic [7:0][31:0] ei;
    logic             bp;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n, abort, s_valid, s_ready, m_valid, m_ready, m_last, busy, frame_done;
  logic [W-1:0]   s_data, m_re, m_im;
  logic [2:0]     m_idx;
  logic [8*W-1:0] core_a, core_xr, core_xi;

  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  int             fd_count = 0;
  int             last_beat_cyc = 0;
  int             stable_cnt = 0;
  logic [8*W-1:0] prev_a = '0;
  vec_t           vecs [6];
  bit             bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  fft8_seq #(.W(W), .CORE_LAT(CL)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_a(core_a), .core_xr(core_xr), .core_xi(core_xi),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // cycle counter, frame_done pulse counter and core-input settle tracking
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    if (frame_done) fd_count <= fd_count + 1;
    stable_cnt <= (core_a == prev_a) ? stable_cnt + 1 : 0;
    prev_a     <= core_a;
  end

  function automatic int to_int(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // reference DFT bin k: {real, imag}
  function automatic logic [63:0] ref_bin(input logic [7:0][31:0] smp, input int k);
    real sr, si, ang, v;
    sr = 0.0;
    si = 0.0;
    for (int n = 0; n < 8; n++) begin
      ang = 2.0 * PI * $itor(k * n) / 8.0;
      v   = $itor($signed(smp[n]));
      sr  = sr + v * $cos(ang);
      si  = si - v * $sin(ang);
    end
    return {32'(to_int(sr)), 32'(to_int(si))};
  endfunction

  // core outputs are garbage until core_a has been stable for CL clocks
  always_comb begin
    logic [63:0] r;
    core_xr = '0;
    core_xi = '0;
    for (int k = 0; k < 8; k++) begin
      r = ref_bin(core_a, k);
      if (stable_cnt >= CL) begin
        core_xr[k*W +: W] = r[63:32];
        core_xi[k*W +: W] = r[31:0];
      end else begin
        core_xr[k*W +: W] = 32'hDEAD_0000 | 32'(k);
        core_xi[k*W +: W] = 32'hBEEF_0000 | 32'(k);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic sendBeat(input logic [31:0] data);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = data;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0][31:0] smp, input bit gaps);
    for (int n = 0; n < 8; n++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      sendBeat(smp[n]);
    end
    last_beat_cyc = cyc;
  endtask

  // collect bins up to stop_at, checking each presented bin every cycle it is shown
  task automatic receiveBins(input vec_t v, input int stop_at);
    int k = 0;
    int guard = 0;
    int pat = 0;
    int fd0;
    bit first = 1'b1;
    fd0 = fd_count;
    while (k < stop_at && guard < 400) begin
      if (m_valid) begin
        if (first) begin
          checkOutput("latency", 32'(cyc - last_beat_cyc), 32'(CL + 2));
          first = 1'b0;
        end
        checkOutput($sformatf("idx_bin%0d", k), 32'(m_idx), 32'(k));
        checkOutput($sformatf("re_bin%0d", k), m_re, v.er[k]);
        checkOutput($sformatf("im_bin%0d", k), m_im, v.ei[k]);
        checkOutput($sformatf("last_bin%0d", k), 32'(m_last), 32'(k == 7));
        checkOutput("busy_unload", 32'(busy), 32'd1);
        checkOutput("core_a_hold", 32'(core_a == v.smp), 32'd1);
`ifndef FFT8_SEQ_OVERLAP_EN
        checkOutput("s_ready_unload", 32'(s_ready), 32'd0);
`endif
        m_ready = v.bp ? bp_pat[pat % 4] : 1'b1;
        pat++;
        if (m_ready) k++;
      end else begin
        checkOutput("s_ready_wait", 32'(s_ready), 32'd0);
        checkOutput("busy_wait", 32'(busy), 32'd1);
        m_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard++;
    end
    if (k < stop_at) checkOutput("bin_timeout", 32'(k), 32'(stop_at));
    if (stop_at == 8) begin
      checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
      checkOutput("m_valid_after", 32'(m_valid), 32'd0);
      checkOutput("busy_after", 32'(busy), 32'd0);
      m_ready = 1'b0;
      @(negedge clk);
      checkOutput("frame_done_single", 32'(frame_done), 32'd0);
      checkOutput("frame_done_count", 32'(fd_count), 32'(fd0 + 1));
    end
    m_ready = 1'b0;
  endtask

  initial begin
    int fd0;
    int x;
    logic [63:0] r;

    vecs[0].smp = {{7{32'd0}}, 32'd1};
    vecs[0].er  = {8{32'd1}};
    vecs[0].ei  = '0;
    vecs[0].bp  = 1'b0;
    vecs[1].smp = {8{32'd1}};
    vecs[1].er  = {{7{32'd0}}, 32'd8};
    vecs[1].ei  = '0;
    vecs[1].bp  = 1'b1;
    for (int i = 2; i < 6; i++) begin
      for (int n = 0; n < 8; n++) begin
        x = int'($urandom_range(0, 2000)) - 1000;
        vecs[i].smp[n] = 32'(x);
      end
      for (int k = 0; k < 8; k++) begin
        r = ref_bin(vecs[i].smp, k);
        vecs[i].er[k] = r[63:32];
        vecs[i].ei[k] = r[31:0];
      end
      vecs[i].bp = 1'(i % 2);
    end

    rst_n   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_m_idx", 32'(m_idx), 32'd0);
    checkOutput("rst_m_re", m_re, 32'd0);
    checkOutput("rst_m_im", m_im, 32'd0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    checkOutput("rst_core_a", 32'(core_a == '0), 32'd1);
    rst_n = 1'b1;
    #1;
    checkOutput("s_ready_release", 32'(s_ready), 32'd0);
    @(negedge clk);
    checkOutput("s_ready_load", 32'(s_ready), 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i].smp, vecs[i].bp);
      receiveBins(vecs[i], 8);
    end

    // abort after 5 samples, with a same-cycle beat that must be dropped
    fd0 = fd_count;
    for (int n = 0; n < 5; n++) sendBeat($urandom_range(1, 100));
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'd77;
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    checkOutput("abort_load_busy", 32'(busy), 32'd0);
    checkOutput("abort_load_s_ready", 32'(s_ready), 32'd1);
    applyStimulus(vecs[0].smp, 1'b1);
    receiveBins(vecs[0], 8);
    checkOutput("abort_fd_count", 32'(fd_count), 32'(fd0 + 1));

    // abort in the middle of draining
    applyStimulus(vecs[2].smp, 1'b0);
    receiveBins(vecs[2], 2);
    fd0   = fd_count;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_unload_m_valid", 32'(m_valid), 32'd0);
    checkOutput("abort_unload_busy", 32'(busy), 32'd0);
    checkOutput("abort_unload_m_idx", 32'(m_idx), 32'd0);
    checkOutput("abort_unload_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    checkOutput("abort_unload_fd_count", 32'(fd_count), 32'(fd0));

    // asynchronous reset while bin 3 is on the output
    applyStimulus(vecs[3].smp, 1'b0);
    receiveBins(vecs[3], 3);
    checkOutput("pre_reset_idx", 32'(m_idx), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_m_idx", 32'(m_idx), 32'd0);
    checkOutput("mid_rst_m_re", m_re, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rst_s_ready_0", 32'(s_ready), 32'd0);
    @(negedge clk);
    checkOutput("mid_rst_s_ready_1", 32'(s_ready), 32'd1);

    for (int i = 3; i < 6; i++) begin
      applyStimulus(vecs[i].smp, vecs[i].bp);
      receiveBins(vecs[i], 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end

endmodule
